hello_ram_arbiter: RTL
======================

# hello_ram_arbiter

Two-master arbiter in front of the 32-bit single-port on-chip RAM of the HELLO system (5000 words, 13-bit word address, byte enables, one-cycle read latency). Each master sees a pipelined Avalon-MM slave with waitrequest and readdatavalid. The block picks one request per cycle, round-robin by default, and drives the RAM's chipselect/write/address/byteenable/writedata. It returns registered read data to the requester that issued each read.

## Interface
- AW, 13: word address width, matches the RAM.
- DW, 32: data width. Byte-enable width is DW/8.
- DEPTH, 5000: legal word count. Addresses >= DEPTH are still forwarded; the RAM response to them is undefined.

- clk  in  1: single clock for all logic.
- reset_n  in  1: asynchronous, active-low reset.
- freeze  in  1: when high, no new grants are issued. Reads already in flight still complete.
- m0_address / m1_address  in  AW: master word address.
- m0_byteenable / m1_byteenable  in  DW/8: byte lanes for writes.
- m0_read / m1_read  in  1: read request.
- m0_write / m1_write  in  1: write request.
- m0_writedata / m1_writedata  in  DW: write data.
- m0_waitrequest / m1_waitrequest  out  1: high = request not accepted this cycle.
- m0_readdata / m1_readdata  out  DW: registered read data.
- m0_readdatavalid / m1_readdatavalid  out  1: one-cycle strobe qualifying readdata.
- ram_address  out  AW: RAM address.
- ram_byteenable  out  DW/8: RAM byte enables.
- ram_chipselect  out  1: RAM chip select.
- ram_write  out  1: RAM write enable.
- ram_writedata  out  DW: RAM write data.
- ram_clken  out  1: RAM clock enable, held at 1.
- ram_readdata  in  DW: unregistered RAM q.

## Operation
- **Request:** a master requests when read|write is high. read&write together is illegal; write wins and no read is returned.
- **Arbitration:** combinational from the requests and a registered last_grant bit (reset value 1, so m0 wins first).
  - One requester: it wins.
  - Both requesting: the master that is not last_grant wins.
  - last_grant updates to the winner on every accepted cycle.
  - freeze=1 means no winner.
- **Winner's cycle:** its waitrequest=0; the loser's waitrequest=1. The RAM outputs follow the winner's signals and ram_chipselect=1.
- **Write:** ram_write=1; the write completes in that cycle.
- **Read:** ram_write=0. The pipeline registers record stage1_valid=1 and stage1_id=winner.
- **Read return:** on the next edge, ram_readdata is captured into the output register of master stage1_id and that master's readdatavalid is set for exactly one cycle.
- **No winner:** ram_chipselect=0, ram_write=0, and both waitrequests=1 for every master that is requesting.
- **Non-requesting masters:** waitrequest=0. This is a don't-care per Avalon, but it is defined so the bench can check it.
- **Throughput:** one transfer per cycle. Back-to-back reads from alternating masters return in issue order.
- **Ordering:** no reordering. A read followed by a write to the same address returns the old data.

## Timing
- **Read latency:** request accepted at edge t, readdatavalid high in cycle t+2 (two cycles).
- **Write latency:** accepted at edge t; a read accepted at t+1 sees the new data.
- **Reset values:**
  - all readdatavalid = 0, readdata = 0
  - pipeline stage valid bits = 0
  - last_grant = 1
  - ram_clken = 1
  - combinational outputs follow the inputs immediately
- **Reset mid-read:** asserting reset_n low drops the pending readdatavalid. After reset no stale strobe appears.
- **freeze rising while a read is in stage1:** that read still returns at t+2.

## Configuration
- **HELLO_ARB_FIXED_PRIO_EN defined:** fixed priority; m0 always wins when both request. last_grant is not implemented.
- **Undefined (default):** round-robin as described above.

## Structure
- **Shared package hello_arb_pkg:**
  - constants AW_DEF=13, DW_DEF=32, DEPTH_DEF=5000
  - typedef master_id_t (1 bit)
  - typedef avl_req_t struct {address, byteenable, read, write, writedata}
- **Sub-module:** one, hello_arb_rr_pick. It takes the request vector and last_grant and produces a one-hot grant. It is the only place the HELLO_ARB_FIXED_PRIO_EN macro is tested.

## Test plan
- **Single write/read:** m0 writes 0xDEADBEEF to address 0x10 with byteenable 0xF, then reads 0x10 → m0_readdatavalid two cycles after acceptance, m0_readdata=0xDEADBEEF, m1 outputs untouched.
- **Contention:** m0 and m1 read addresses 1 and 2 continuously from reset → grants alternate m0, m1, m0...; readdatavalid alternates each cycle with matching data; with HELLO_ARB_FIXED_PRIO_EN, m1 is starved while m0 requests.
- **Byte lanes:** write 0x11223344 then byteenable 0x2 with writedata 0xAABBCCDD to the same address → a read returns 0x1122CC44.
- **Freeze:** m1 read accepted, freeze asserted the next cycle → m1 data still returns; both waitrequests stay high until freeze drops.
- **Reset mid-read:** m0 read accepted, reset_n low in cycle t+1 → no readdatavalid, outputs at reset values; the first grant after reset goes to m0.
- **Read-after-write, cross-master:** m0 writes 0x5 to address 7 at edge t, m1 reads address 7 at t+1 → m1_readdata=0x5.

Source files
------------

// File: rtl/hello_ram_arbiter_pkg.sv
// hello_ram_arbiter: shared constants, request bundle and id helper.
// Optional: HELLO_ARB_FIXED_PRIO_EN (tested only in hello_arb_rr_pick).
package hello_arb_pkg;

  localparam int AW_DEF    = 13;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 5000;
  localparam int BE_DEF    = DW_DEF / 8;

  typedef logic master_id_t;

  typedef struct packed {
    logic [AW_DEF-1:0] address;
    logic [BE_DEF-1:0] byteenable;
    logic              read;
    logic              write;
    logic [DW_DEF-1:0] writedata;
  } avl_req_t;

  function automatic logic [1:0] id2onehot(
    input master_id_t id
  );
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/hello_ram_arbiter_if.sv
// hello_ram_arbiter: two Avalon-MM slave ports plus the RAM side.
// master = requesters and RAM model; slave = the arbiter.
interface hello_ram_arbiter_if
  import hello_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic            freeze;

  logic [AW-1:0]   m0_address;
  logic [DW/8-1:0] m0_byteenable;
  logic            m0_read;
  logic            m0_write;
  logic [DW-1:0]   m0_writedata;
  logic            m0_waitrequest;
  logic [DW-1:0]   m0_readdata;
  logic            m0_readdatavalid;

  logic [AW-1:0]   m1_address;
  logic [DW/8-1:0] m1_byteenable;
  logic            m1_read;
  logic            m1_write;
  logic [DW-1:0]   m1_writedata;
  logic            m1_waitrequest;
  logic [DW-1:0]   m1_readdata;
  logic            m1_readdatavalid;

  logic [AW-1:0]   ram_address;
  logic [DW/8-1:0] ram_byteenable;
  logic            ram_chipselect;
  logic            ram_write;
  logic [DW-1:0]   ram_writedata;
  logic            ram_clken;
  logic [DW-1:0]   ram_readdata;

  modport master (
    output freeze,
    output m0_address, m0_byteenable,
    output m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata,
    input  m0_readdatavalid,
    output m1_address, m1_byteenable,
    output m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata,
    input  m1_readdatavalid,
    input  ram_address, ram_byteenable,
    input  ram_chipselect, ram_write,
    input  ram_writedata, ram_clken,
    output ram_readdata
  );

  modport slave (
    input  freeze,
    input  m0_address, m0_byteenable,
    input  m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata,
    output m0_readdatavalid,
    input  m1_address, m1_byteenable,
    input  m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata,
    output m1_readdatavalid,
    output ram_address, ram_byteenable,
    output ram_chipselect, ram_write,
    output ram_writedata, ram_clken,
    input  ram_readdata
  );

endinterface

// File: rtl/hello_ram_arbiter_rr_pick.sv
// hello_arb_rr_pick: one-hot grant from two requests and last_grant.
// HELLO_ARB_FIXED_PRIO_EN selects fixed m0-first priority.
module hello_arb_rr_pick
  import hello_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_id_t last_grant_i,
  output logic [1:0] gnt_o
);

`ifdef HELLO_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end
`else
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // contention: whoever did not win last time
      2'b11:   gnt_o = id2onehot(~last_grant_i);
      default: gnt_o = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/hello_ram_arbiter.sv
// hello_ram_arbiter: two-master arbiter for the HELLO on-chip RAM.
// Optional macro HELLO_ARB_FIXED_PRIO_EN: fixed m0 priority.
module hello_ram_arbiter
  import hello_arb_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
)(
  input logic clk,
  input logic reset_n,
  hello_ram_arbiter_if.slave bus
);

  // out-of-range addresses are forwarded as-is
  logic unused_depth;
  assign unused_depth = (DEPTH > 0);

  avl_req_t   r0, r1, sel;
  logic [1:0] req;
  logic [1:0] pick_gnt;
  logic [1:0] gnt;
  logic       accept;
  master_id_t win_id;

  master_id_t    last_grant_q, last_grant_d;
  logic          st1_valid_q, st1_valid_d;
  master_id_t    st1_id_q, st1_id_d;
  logic [1:0]    rdv_q, rdv_d;
  logic [DW-1:0] rd0_q, rd0_d;
  logic [DW-1:0] rd1_q, rd1_d;

  assign r0 = '{
    address:    bus.m0_address,
    byteenable: bus.m0_byteenable,
    read:       bus.m0_read,
    write:      bus.m0_write,
    writedata:  bus.m0_writedata
  };

  assign r1 = '{
    address:    bus.m1_address,
    byteenable: bus.m1_byteenable,
    read:       bus.m1_read,
    write:      bus.m1_write,
    writedata:  bus.m1_writedata
  };

  assign req[0] = r0.read | r0.write;
  assign req[1] = r1.read | r1.write;

  hello_arb_rr_pick u_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .gnt_o        (pick_gnt)
  );

  assign gnt    = bus.freeze ? 2'b00 : pick_gnt;
  assign accept = |gnt;
  assign win_id = gnt[1];
  assign sel    = win_id ? r1 : r0;

  assign bus.ram_chipselect = accept;
  assign bus.ram_write      = accept & sel.write;
  assign bus.ram_address    = sel.address;
  assign bus.ram_byteenable = sel.byteenable;
  assign bus.ram_writedata  = sel.writedata;
  assign bus.ram_clken      = 1'b1;

  assign bus.m0_waitrequest = req[0] & ~gnt[0];
  assign bus.m1_waitrequest = req[1] & ~gnt[1];

  always_comb begin
    last_grant_d = last_grant_q;
    st1_valid_d  = 1'b0;
    st1_id_d     = win_id;
    rdv_d        = 2'b00;
    rd0_d        = rd0_q;
    rd1_d        = rd1_q;
    if (accept) begin
      last_grant_d = win_id;
      // write beats read when both are raised
      st1_valid_d  = ~sel.write;
    end
    if (st1_valid_q) begin
      if (st1_id_q) begin
        rdv_d[1] = 1'b1;
        rd1_d    = bus.ram_readdata;
      end else begin
        rdv_d[0] = 1'b1;
        rd0_d    = bus.ram_readdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      st1_valid_q  <= 1'b0;
      st1_id_q     <= 1'b0;
      rdv_q        <= 2'b00;
      rd0_q        <= '0;
      rd1_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      st1_valid_q  <= st1_valid_d;
      st1_id_q     <= st1_id_d;
      rdv_q        <= rdv_d;
      rd0_q        <= rd0_d;
      rd1_q        <= rd1_d;
    end
  end

  assign bus.m0_readdata      = rd0_q;
  assign bus.m1_readdata      = rd1_q;
  assign bus.m0_readdatavalid = rdv_q[0];
  assign bus.m1_readdatavalid = rdv_q[1];

endmodule
